// File: rtl/piezo_decoder.sv
// piezo_decoder: measures piezo tone half-periods, confirms notes, spots fanfare sequences and differential faults
module piezo_decoder #(
    parameter int HP_G6       = 15944,
    parameter int HP_C7       = 11945,
    parameter int HP_E7       = 9480,
    parameter int HP_G7       = 7972,
    parameter int TOL         = 200,
    parameter int CONFIRM     = 4,
    parameter int SILENT_CNT  = 500000,
    parameter int DIFF_GLITCH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        piezo,
    input  logic        piezo_n,
    output logic [19:0] half_period,
    output logic [2:0]  note,
    output logic        note_vld,
    output logic        note_new,
    output logic        silent,
    output logic        fwd_det,
    output logic        rev_det,
    output logic        diff_err
);
    localparam int RW = $clog2(CONFIRM + 1);
    localparam int DW = $clog2(DIFF_GLITCH + 2);
    localparam logic [19:0] CNT_MAX = '1;
    localparam logic [2:0] FWD [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd0, 3'd0};
    localparam logic [2:0] REV [8] = '{3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

    logic          p_s1, p_s2, n_s1, n_s2, p_prev;
    logic          edge_det, capture, eq;
    logic [19:0]   cnt;
    logic [2:0]    cls, last_cls, fidx, ridx, fidx_nxt, ridx_nxt;
    logic [RW-1:0] run, run_nxt;
    logic [DW-1:0] dcnt;

    function automatic logic in_win(input logic [19:0] c, input int hp);
        return int'(c) >= hp - TOL && int'(c) <= hp + TOL;
    endfunction

    // a mismatching note may itself be the first element, so it re-arms at 1
    always_comb begin
        edge_det = p_s2 != p_prev;
        capture  = edge_det && !silent;
        eq       = p_s2 == n_s2;
        cls      = in_win(cnt, HP_G6) ? 3'd1 :
                   in_win(cnt, HP_C7) ? 3'd2 :
                   in_win(cnt, HP_E7) ? 3'd3 :
                   in_win(cnt, HP_G7) ? 3'd4 : 3'd0;
        run_nxt  = cls == 3'd0 ? '0 :
                   cls != last_cls ? RW'(1) :
                   run == RW'(CONFIRM) ? run : run + 1'b1;
        fidx_nxt = fidx == 3'd6 ? 3'd0 :
                   !note_new ? fidx :
                   note == FWD[fidx] ? fidx + 3'd1 :
                   note == FWD[0] ? 3'd1 : 3'd0;
        ridx_nxt = ridx == 3'd6 ? 3'd0 :
                   !note_new ? ridx :
                   note == REV[ridx] ? ridx + 3'd1 :
                   note == REV[0] ? 3'd1 : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_s1        <= 1'b0;
            p_s2        <= 1'b0;
            n_s1        <= 1'b0;
            n_s2        <= 1'b0;
            p_prev      <= 1'b0;
            cnt         <= '0;
            half_period <= '0;
            note        <= '0;
            note_new    <= 1'b0;
            silent      <= 1'b1;
            fwd_det     <= 1'b0;
            rev_det     <= 1'b0;
            diff_err    <= 1'b0;
            last_cls    <= '0;
            run         <= '0;
            fidx        <= '0;
            ridx        <= '0;
            dcnt        <= '0;
        end else begin
            p_s1     <= piezo;
            p_s2     <= p_s1;
            n_s1     <= piezo_n;
            n_s2     <= n_s1;
            p_prev   <= p_s2;
            cnt      <= edge_det ? 20'd1 : cnt == CNT_MAX ? cnt : cnt + 20'd1;
            note_new <= 1'b0;
            fwd_det  <= fidx == 3'd6;
            rev_det  <= ridx == 3'd6;
            fidx     <= fidx_nxt;
            ridx     <= ridx_nxt;
            dcnt     <= !eq ? '0 : dcnt > DW'(DIFF_GLITCH) ? dcnt : dcnt + 1'b1;
            if (eq && dcnt >= DW'(DIFF_GLITCH))
                diff_err <= 1'b1;
            if (edge_det)
                silent <= 1'b0;
            // while silent an edge only restarts the counter; captures resume after it
            if (capture) begin
                half_period <= cnt;
                last_cls    <= cls;
                run         <= run_nxt;
                if (run_nxt == RW'(CONFIRM) && cls != note) begin
                    note     <= cls;
                    note_new <= 1'b1;
                end
            end else if (!edge_det && cnt == 20'(SILENT_CNT)) begin
                silent   <= 1'b1;
                note     <= '0;
                run      <= '0;
                last_cls <= '0;
                fidx     <= '0;
                ridx     <= '0;
            end
        end
    end

    assign note_vld = note != 3'd0;
endmodule

// File: tb/tb_piezo_decoder.sv
// tb_piezo_decoder: scaled-period vector table plus scoreboard of confirmed notes for piezo_decoder
module tb_piezo_decoder;
    localparam int G6 = 160, C7 = 120, E7 = 95, G7 = 80, SIL = 1000;

    logic        clk = 1'b0, rst = 1'b1, piezo = 1'b0, piezo_n = 1'b1;
    logic [19:0] half_period;
    logic [2:0]  note;
    logic        note_vld, note_new, silent, fwd_det, rev_det, diff_err;

    piezo_decoder #(
        .HP_G6(G6), .HP_C7(C7), .HP_E7(E7), .HP_G7(G7), .TOL(8),
        .CONFIRM(4), .SILENT_CNT(SIL), .DIFF_GLITCH(8)
    ) dut (
        .clk(clk), .rst(rst), .piezo(piezo), .piezo_n(piezo_n),
        .half_period(half_period), .note(note), .note_vld(note_vld),
        .note_new(note_new), .silent(silent), .fwd_det(fwd_det),
        .rev_det(rev_det), .diff_err(diff_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int hp;
        int n;
        int note;
        bit newn;
        int fwd;
        int rev;
    } seg_t;

    int         vectors = 0, errors = 0, fwd_cnt = 0, rev_cnt = 0;
    logic [2:0] exp_q[$];
    logic       nn_prev = 1'b0;
    seg_t       segs[24];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (note_new) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL note_new: unexpected pulse with note=%0d", note);
                end else
                    check("note_new note", int'(note), int'(exp_q.pop_front()));
                if (nn_prev) begin
                    vectors++;
                    errors++;
                    $display("FAIL note_new width: high for 2+ cycles, expected 1");
                end
            end
            if (fwd_det) fwd_cnt++;
            if (rev_det) rev_cnt++;
        end
        nn_prev = note_new;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        piezo = 1'b0;
        piezo_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        fwd_cnt = 0;
        rev_cnt = 0;
        @(negedge clk);
    endtask

    // each toggle is spaced hp cycles from the previous one, so the first
    // capture of a tone measures the preceding tone's half-period
    task automatic tone(input int hp, input int n);
        repeat (n) begin
            @(posedge clk);
            #1 piezo = ~piezo;
            piezo_n = ~piezo;
            repeat (hp - 1) @(posedge clk);
        end
    endtask

    task automatic hold_equal(input int cycles);
        repeat (4) @(posedge clk);
        #1 piezo = 1'b1;
        piezo_n = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 piezo = 1'b0;
        piezo_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        segs = '{
            '{1, G6,  6, 1, 1, 0, 0},
            '{0, 126, 6, 2, 1, 0, 0},
            '{0, 130, 6, 2, 0, 0, 0},
            '{1, G6,  8, 1, 1, 0, 0},
            '{0, C7,  8, 2, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G7,  8, 4, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G7,  8, 4, 1, 1, 0},
            '{1, G7,  8, 4, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G7,  8, 4, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, C7,  8, 2, 1, 0, 0},
            '{0, G6,  8, 1, 1, 0, 1},
            '{1, G6,  8, 1, 1, 0, 0},
            '{0, C7,  8, 2, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G6,  8, 1, 1, 0, 0},
            '{0, C7,  8, 2, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G7,  8, 4, 1, 0, 0},
            '{0, E7,  8, 3, 1, 0, 0},
            '{0, G7,  8, 4, 1, 1, 0}
        };

        do_reset();
        check("reset half_period", int'(half_period), 0);
        check("reset note", int'(note), 0);
        check("reset note_vld", int'(note_vld), 0);
        check("reset note_new", int'(note_new), 0);
        check("reset silent", int'(silent), 1);
        check("reset fwd_det", int'(fwd_det), 0);
        check("reset rev_det", int'(rev_det), 0);
        check("reset diff_err", int'(diff_err), 0);

        for (int i = 0; i < 24; i++) begin
            if (segs[i].rst) do_reset();
            if (segs[i].newn) exp_q.push_back(3'(segs[i].note));
            tone(segs[i].hp, segs[i].n);
            @(negedge clk);
            check($sformatf("seg%0d half_period", i), int'(half_period), segs[i].hp);
            check($sformatf("seg%0d note", i), int'(note), segs[i].note);
            check($sformatf("seg%0d note_vld", i), int'(note_vld), int'(segs[i].note != 0));
            check($sformatf("seg%0d silent", i), int'(silent), 0);
            check($sformatf("seg%0d pending notes", i), exp_q.size(), 0);
            check($sformatf("seg%0d fwd_det count", i), fwd_cnt, segs[i].fwd);
            check($sformatf("seg%0d rev_det count", i), rev_cnt, segs[i].rev);
        end

        // silence mid-sequence clears note and both sequence indices
        do_reset();
        exp_q.push_back(3'd1);
        tone(G6, 8);
        exp_q.push_back(3'd2);
        tone(C7, 8);
        exp_q.push_back(3'd3);
        tone(E7, 8);
        @(negedge clk);
        check("pre-silence silent", int'(silent), 0);
        check("pre-silence note", int'(note), 3);
        repeat (SIL + 10) @(posedge clk);
        @(negedge clk);
        check("silence silent", int'(silent), 1);
        check("silence note", int'(note), 0);
        check("silence note_vld", int'(note_vld), 0);
        exp_q.push_back(3'd4);
        tone(G7, 8);
        exp_q.push_back(3'd3);
        tone(E7, 8);
        exp_q.push_back(3'd4);
        tone(G7, 8);
        @(negedge clk);
        check("resume silent", int'(silent), 0);
        check("resume note", int'(note), 4);
        check("resume pending notes", exp_q.size(), 0);
        check("resume fwd_det count", fwd_cnt, 0);
        check("resume rev_det count", rev_cnt, 0);

        // one-cycle reset in the middle of a tone
        do_reset();
        exp_q.push_back(3'd1);
        tone(G6, 8);
        tone(G6, 3);
        @(negedge clk);
        check("pre-rst note", int'(note), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid-rst note", int'(note), 0);
        check("mid-rst silent", int'(silent), 1);
        check("mid-rst half_period", int'(half_period), 0);
        check("mid-rst note_vld", int'(note_vld), 0);
        tone(G6, 4);
        @(negedge clk);
        check("post-rst 3 captures note", int'(note), 0);
        exp_q.push_back(3'd1);
        tone(G6, 2);
        @(negedge clk);
        check("post-rst 4 captures note", int'(note), 1);
        check("post-rst pending notes", exp_q.size(), 0);

        // differential fault: 8 equal cycles tolerated, 9 latch the flag
        do_reset();
        hold_equal(8);
        check("diff 8 cycles diff_err", int'(diff_err), 0);
        hold_equal(9);
        check("diff 9 cycles diff_err", int'(diff_err), 1);
        exp_q.push_back(3'd1);
        tone(G6, 8);
        @(negedge clk);
        check("diff good tone note", int'(note), 1);
        check("diff good tone diff_err", int'(diff_err), 1);
        check("diff pending notes", exp_q.size(), 0);
        do_reset();
        check("diff after rst diff_err", int'(diff_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
